// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the shared-mux arbiter.
// Optional build macro: MUX4_ARB_LOCK_EN adds the 'lock' signal.
//
// Handshake: each req[i] is a level request. Requester i raises it and holds
// it high for as long as it needs the mux. It owns the mux in every cycle
// where gnt[i]=1, and it gives the mux up by dropping req[i]. gnt, sel and
// valid are registered, and valid == |gnt.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

`ifdef MUX4_ARB_LOCK_EN
  modport master (output req, output lock, input gnt, input sel, input valid);
  modport slave  (input req, input lock, output gnt, output sel, output valid);
`else
  modport master (output req, input gnt, input sel, input valid);
  modport slave  (input req, output gnt, output sel, output valid);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for one 4:1 mux shared by four requesters.
// sel drives the mux S1/S0 pins directly, so sel=i selects input Ii.
// Optional build macro: MUX4_ARB_LOCK_EN lets the current owner suppress
// hold-limit preemption while lock=1.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8  // 0 = unlimited, otherwise 2..255
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus,
  output logic              o_dbg_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam bit         LP_HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] LP_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [3:0] r_gnt;
  logic       r_valid;
  logic [7:0] r_hold_cnt;

  state_t     w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [1:0] w_owner_nxt;
  logic [3:0] w_gnt_nxt;
  logic       w_valid_nxt;
  logic [7:0] w_hold_nxt;
  logic [3:0] w_others;
  logic [1:0] w_win;
  logic       w_lock;
  logic       w_preempt;

`ifdef MUX4_ARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  // First set bit of r searching p, p+1, p+2, p+3 (mod 4); callers guard with |r.
  function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    f_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) f_pick = idx;
    end
  endfunction

  // Requests from everyone except the current owner; this set is used for both handoff and preemption.
  assign w_others = bus.req & ~(4'b0001 << r_owner);

  // The hold limit is compared with >= rather than ==. The count keeps running
  // while lock holds off preemption, and with >= preemption still fires once
  // lock is released.
  assign w_preempt = LP_HOLD_EN && (r_hold_cnt >= LP_HOLD_LAST) && (|w_others) && !w_lock;

  // Next-state and next-output logic for the IDLE/BUSY machine.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_hold_nxt  = r_hold_cnt;
    w_win       = 2'd0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
        if (|bus.req) begin
          w_win       = f_pick(bus.req, r_ptr);
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_win;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd0;
          w_ptr_nxt   = w_win + 2'd1;
        end
      end
      ST_BUSY: begin
        if (!bus.req[r_owner] || w_preempt) begin
          // r_ptr is already owner+1, so this search skips the outgoing owner.
          if (|w_others) begin
            w_win       = f_pick(w_others, r_ptr);
            w_owner_nxt = w_win;
            w_gnt_nxt   = 4'b0001 << w_win;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = 8'd0;
            w_ptr_nxt   = w_win + 2'd1;
          end else begin
            // No other requester: drop to IDLE and leave sel on the old owner.
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
          end
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; reset clears everything and drops any grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_owner    <= 2'd0;
      r_gnt      <= 4'b0000;
      r_valid    <= 1'b0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_gnt      <= w_gnt_nxt;
      r_valid    <= w_valid_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.sel    = r_owner;
  assign bus.valid  = r_valid;
  assign o_dbg_busy = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with the default MAX_HOLD=8.
// The driver pushes the hand-computed {gnt, sel, valid} for each edge into a
// queue. The monitor pops that entry and compares it 1 ns after the edge.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;
  logic dbg_busy;
  int   total;
  int   bad;
  int   step_no;

  logic [6:0] exp_q[$];
  int         id_q[$];

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_busy (dbg_busy)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the expected outputs after the next edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic lock,
                      input logic [3:0] g, input logic [1:0] s, input logic v);
    @(negedge clk);
    rst_n   = rst;
    bus.req = req;
`ifdef MUX4_ARB_LOCK_EN
    bus.lock = lock;
`else
    if (lock) begin end
`endif
    exp_q.push_back({g, s, v});
    id_q.push_back(step_no);
    step_no++;
  endtask

  // Scoreboard monitor: compare the DUT outputs after each edge that has a queued expectation.
  initial begin
    logic [6:0] exp_v;
    logic [6:0] act_v;
    int         id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        id    = id_q.pop_front();
        act_v = {bus.gnt, bus.sel, bus.valid};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL step%0d gnt/sel/valid got=%b_%b_%b want=%b_%b_%b", id,
                   act_v[6:3], act_v[2:1], act_v[0], exp_v[6:3], exp_v[2:1], exp_v[0]);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    total   = 0;
    bad     = 0;
    step_no = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset with every requester asserted, then the first grant goes to 0.
    step(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    step(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1);

    // Round-robin: each owner drops req for one cycle after 3 cycles.
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1);
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1);
    step(1, 4'b1110, 0, 4'b0010, 2'd1, 1);
    step(1, 4'b1111, 0, 4'b0010, 2'd1, 1);
    step(1, 4'b1111, 0, 4'b0010, 2'd1, 1);
    step(1, 4'b1101, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b1111, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b1111, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b1011, 0, 4'b1000, 2'd3, 1);
    step(1, 4'b1111, 0, 4'b1000, 2'd3, 1);
    step(1, 4'b1111, 0, 4'b1000, 2'd3, 1);
    step(1, 4'b0111, 0, 4'b0001, 2'd0, 1);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0);

    // Preemption: owner 2 is granted, req[1] rises in cycle 3, and 2 holds for exactly 8 cycles.
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    for (int i = 0; i < 5; i++) step(1, 4'b0110, 0, 4'b0100, 2'd2, 1);
    step(1, 4'b0110, 0, 4'b0010, 2'd1, 1);

    // Release to idle keeps sel=1; the next search starts from 2, so 0 wins.
    step(1, 4'b0000, 0, 4'b0000, 2'd1, 0);
    step(1, 4'b0011, 0, 4'b0001, 2'd0, 1);
    // Reset mid-grant clears every output at that edge.
    step(0, 4'b0011, 0, 4'b0000, 2'd0, 0);
    step(1, 4'b0011, 0, 4'b0001, 2'd0, 1);

    // Sole requester 3 keeps the grant well past MAX_HOLD.
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1);
    for (int i = 0; i < 40; i++) step(1, 4'b1000, 0, 4'b1000, 2'd3, 1);
    step(1, 4'b0000, 0, 4'b0000, 2'd3, 0);

`ifdef MUX4_ARB_LOCK_EN
    // Lock: owner 0 keeps the grant against req[1]; preemption happens as soon as lock drops.
    step(1, 4'b0011, 1, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 20; i++) step(1, 4'b0011, 1, 4'b0001, 2'd0, 1);
    step(1, 4'b0011, 0, 4'b0010, 2'd1, 1);
    step(1, 4'b0000, 0, 4'b0000, 2'd1, 0);
`endif

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
